// File: rtl/life_pkg.sv
// life_pkg: shared FSM states, neighbour bit positions and default board size
// for the Game-of-Life step engine.
package life_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    localparam logic [2:0] DIR_N  = 3'd0;
    localparam logic [2:0] DIR_NE = 3'd1;
    localparam logic [2:0] DIR_E  = 3'd2;
    localparam logic [2:0] DIR_SE = 3'd3;
    localparam logic [2:0] DIR_S  = 3'd4;
    localparam logic [2:0] DIR_SW = 3'd5;
    localparam logic [2:0] DIR_W  = 3'd6;
    localparam logic [2:0] DIR_NW = 3'd7;

    localparam int LIFE_ROWS = 16;
    localparam int LIFE_COLS = 16;

endpackage

// File: rtl/dotCount.sv
// dotCount: counts live bits in an 8-bit neighbour vector; counts of 4 or more
// report as 0, which the life rule treats as death anyway.
module dotCount (
    input  logic [7:0] i_dots,
    output logic [1:0] o_count
);

    logic [3:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 8; i++) w_sum = w_sum + {3'b000, i_dots[i]};
        o_count = (w_sum >= 4'd4) ? 2'd0 : w_sum[1:0];
    end

endmodule

// File: rtl/neighbour_gather.sv
// neighbour_gather: combinational fetch of the 8 neighbours of cell (i_row, i_col)
// plus the cell itself, with dead or toroidal edges selected by WRAP.
module neighbour_gather
    import life_pkg::*;
#(
    parameter int ROWS = LIFE_ROWS,
    parameter int COLS = LIFE_COLS,
    parameter int WRAP = 0,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic [ROWS-1:0][COLS-1:0] i_board,
    input  logic [RW-1:0]             i_row,
    input  logic [CW-1:0]             i_col,
    output logic [7:0]                o_nbr,
    output logic                      o_cur
);

    function automatic logic at(input int dr, input int dc);
        int r, c;
        r = int'(i_row) + dr;
        c = int'(i_col) + dc;
        if (WRAP != 0) begin
            r = (r + ROWS) % ROWS;
            c = (c + COLS) % COLS;
        end else if (r < 0 || r >= ROWS || c < 0 || c >= COLS) begin
            return 1'b0;
        end
        return i_board[RW'(r)][CW'(c)];
    endfunction

    always_comb begin
        o_nbr         = '0;
        o_nbr[DIR_N]  = at(-1,  0);
        o_nbr[DIR_NE] = at(-1,  1);
        o_nbr[DIR_E]  = at( 0,  1);
        o_nbr[DIR_SE] = at( 1,  1);
        o_nbr[DIR_S]  = at( 1,  0);
        o_nbr[DIR_SW] = at( 1, -1);
        o_nbr[DIR_W]  = at( 0, -1);
        o_nbr[DIR_NW] = at(-1, -1);
        o_cur         = i_board[i_row][i_col];
    end

endmodule

// File: rtl/life_step_engine.sv
// life_step_engine: holds the life board and computes one generation per start,
// scanning one cell per clock into a shadow board committed in a single edge.
module life_step_engine
    import life_pkg::*;
#(
    parameter int ROWS = LIFE_ROWS,
    parameter int COLS = LIFE_COLS,
    parameter int WRAP = 0,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [CW-1:0]   wr_col,
    input  logic            wr_data,
    input  logic [RW-1:0]   rd_row,
    output logic [COLS-1:0] rd_data,
    output logic            busy,
    output logic            done
);

    state_t                   r_state, w_next;
    logic [ROWS-1:0][COLS-1:0] r_board, r_shadow;
    logic [RW-1:0]            r_row;
    logic [CW-1:0]            r_col;
    logic                     r_done;
    logic [7:0]               w_nbr;
    logic [1:0]               w_count;
    logic                     w_cur, w_new, w_last_col, w_last;

    neighbour_gather #(.ROWS(ROWS), .COLS(COLS), .WRAP(WRAP)) u_gather (
        .i_board(r_board),
        .i_row  (r_row),
        .i_col  (r_col),
        .o_nbr  (w_nbr),
        .o_cur  (w_cur)
    );

    dotCount u_dot (
        .i_dots (w_nbr),
        .o_count(w_count)
    );

    assign w_last_col = r_col == CW'(COLS - 1);
    assign w_last     = w_last_col && r_row == RW'(ROWS - 1);
    assign w_new      = (w_count == 2'd3) || (w_count == 2'd2 && w_cur);
    assign rd_data    = r_board[rd_row];
    assign busy       = r_state != IDLE;
    assign done       = r_done;

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (start ? SCAN : IDLE)
               : (r_state == SCAN) ? (w_last ? COMMIT : SCAN)
               : IDLE;
    end

    // Reset also discards any partially built shadow generation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_row    <= '0;
            r_col    <= '0;
            r_board  <= '0;
            r_shadow <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= r_state == COMMIT;
            if (r_state == IDLE) begin
                if (wr_en) r_board[wr_row][wr_col] <= wr_data;
                if (start) begin
                    r_row <= '0;
                    r_col <= '0;
                end
            end else if (r_state == SCAN) begin
                r_shadow[r_row][r_col] <= w_new;
                r_col <= w_last_col ? '0 : r_col + 1'b1;
                if (w_last_col) r_row <= w_last ? '0 : r_row + 1'b1;
            end else begin
                r_board <= r_shadow;
            end
        end
    end

endmodule
